cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-handling sequencer between the 4-way write-back data cache and the slow main-memory port. When the cache reports a miss it evicts the victim word to memory if it is dirty, fetches the missing word for read misses, and returns it to the cache on a one-cycle fill pulse. It holds the memory handshake stable, bounds every access with a watchdog, and keeps saturating miss and writeback counters for performance analysis.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 256, cycles a memory access may wait for mem_ack before abort (≥2)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  cache miss (level, = !Hit); sampled only in IDLE
- miss_we  in  1  missing access is a store (no fetch needed)
- miss_addr  in  ADDR_W  address of missing word
- wb_req  in  1  victim valid and dirty (MemWrite2Memory)
- wb_addr  in  ADDR_W  victim address (MissAddr)
- wb_data  in  DATA_W  victim data (Data2Memory)
- busy  out  1  miss in progress; cache/pipeline stalls
- fill_valid  out  1  one-cycle pulse: cache line may be written
- fill_data  out  DATA_W  fetched word (0 for store miss or timeout)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- err  out  1  sticky: an access timed out
- miss_cnt  out  CNT_W  accepted misses, saturating
- wb_cnt  out  CNT_W  completed writebacks, saturating

## Operation
- States: IDLE, WB, RD, DONE.
- IDLE: on miss_req=1 capture miss_addr, miss_we, wb_req, wb_addr, wb_data into registers; miss_cnt+1. Next state WB if wb_req, else RD if !miss_we, else DONE.
- WB: mem_req=1, mem_we=1, mem_addr/mem_wdata = captured victim. On mem_ack: wb_cnt+1; next RD if !miss_we else DONE.
- RD: mem_req=1, mem_we=0, mem_addr = captured miss address. On mem_ack: fill_data <= mem_rdata; next DONE.
- DONE: fill_valid=1 for exactly one cycle; next IDLE.
- Watchdog: counter cleared on entry to WB/RD, increments each cycle mem_req=1 without ack; on reaching TIMEOUT-1: err<=1, fill_data<=0, skip remaining accesses, go DONE.
- mem_ack and timeout in the same cycle: ack wins, no err.
- mem_ack outside WB/RD ignored.
- Captured values are used throughout; input changes while busy have no effect.
- Counters saturate at all-ones, never wrap.

## Timing
- Reset (async, immediate): state IDLE; busy, fill_valid, mem_req, mem_we, err = 0; mem_addr, mem_wdata, fill_data, miss_cnt, wb_cnt = 0. Reset during WB/RD drops mem_req asynchronously; no fill issued.
- All outputs registered or decoded from state only; no input-to-output combinational path.
- busy = (state != IDLE); rises the cycle after miss_req sampled.
- mem_req/mem_we/mem_addr/mem_wdata stable from state entry until the cycle after mem_ack.
- Clean read miss, ack in first RD cycle: miss at cycle 0, mem_req cycles 1, fill_valid cycle 2.
- Dirty read miss, single-cycle acks: WB cycle 1, RD cycle 2, fill_valid cycle 3.
- Back-to-back WB→RD: mem_req stays high, mem_we/mem_addr change at the same edge.
- miss_req must fall the cycle after fill_valid (cache now hits); if still high in IDLE it is a new miss.

## Structure
- Package cache_refill_pkg: state enum (IDLE, WB, RD, DONE), default parameter constants.
- Sub-module mem_watchdog: clear/enable/expire counter, width $clog2(TIMEOUT).

## Test plan
- Clean read miss 0x0000_0400, memory acks 1 cycle after req with 0xDEADBEEF → one RD read at 0x400, fill_valid at cycle 2 with 0xDEADBEEF, miss_cnt=1, wb_cnt=0.
- Dirty read miss: victim 0x0000_0800 data 0x12345678, miss 0x0000_0C00 → write 0x12345678 to 0x800 then read 0xC00, wb_cnt=1, fill after both acks.
- Dirty store miss → only write to victim address, no read, fill_valid with fill_data=0.
- Memory never acks, TIMEOUT=8 → mem_req high 8 cycles, err=1, fill_valid with 0, returns IDLE; next miss served normally, err stays 1.
- Assert rst_n low mid-RD → mem_req, busy drop immediately; after release IDLE, counters 0, no fill_valid.
- miss_cnt with CNT_W=4 after 20 misses → 0xF; stray mem_ack in IDLE → no state change.

Source files
------------

// File: rtl/cache_refill_pkg.sv
// Shared types and default sizing for the cache miss refill sequencer.
package cache_refill_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 256;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts stalled request cycles and flags expiry on the last allowed one.
module mem_watchdog #(
    parameter int TIMEOUT = 256,
    localparam int W = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + W'(1);
    end

    // Gated by enable so an ack in the final cycle takes precedence.
    assign o_expire = i_en && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling sequencer: optional victim writeback, optional fetch, one-cycle fill pulse.
module cache_refill_ctrl
    import cache_refill_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic              miss_we,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    refill_state_e     r_state;
    logic              r_miss_we;
    logic [ADDR_W-1:0] r_miss_addr;
    logic [DATA_W-1:0] r_fill_data;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic [CNT_W-1:0]  r_wb_cnt;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_expire;

    // Restart the watchdog on every entry into an access state, including WB->RD.
    assign w_wd_clr = ((r_state == S_IDLE) && miss_req && (wb_req || !miss_we)) ||
                      ((r_state == S_WB) && mem_ack && !r_miss_we);
    assign w_wd_en  = r_mem_req && !mem_ack;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_miss_we   <= 1'b0;
            r_miss_addr <= '0;
            r_fill_data <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
            r_miss_cnt  <= '0;
            r_wb_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_req) begin
                        r_miss_we   <= miss_we;
                        r_miss_addr <= miss_addr;
                        r_fill_data <= '0;
                        if (r_miss_cnt != '1)
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        if (wb_req) begin
                            r_state     <= S_WB;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= wb_addr;
                            r_mem_wdata <= wb_data;
                        end else if (!miss_we) begin
                            r_state    <= S_RD;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= miss_addr;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        if (r_wb_cnt != '1)
                            r_wb_cnt <= r_wb_cnt + CNT_W'(1);
                        if (!r_miss_we) begin
                            r_state    <= S_RD;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_miss_addr;
                        end else begin
                            r_state   <= S_DONE;
                            r_mem_req <= 1'b0;
                        end
                    end else if (w_expire) begin
                        r_err       <= 1'b1;
                        r_fill_data <= '0;
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_fill_data <= mem_rdata;
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                    end else if (w_expire) begin
                        r_err       <= 1'b1;
                        r_fill_data <= '0;
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign fill_valid = (r_state == S_DONE);
    assign fill_data  = r_fill_data;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign err        = r_err;
    assign miss_cnt   = r_miss_cnt;
    assign wb_cnt     = r_wb_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a simple acking memory responder.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        miss_req;
    logic        miss_we;
    logic [31:0] miss_addr;
    logic        wb_req;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    wire         mem_ack;
    logic        err;
    logic [3:0]  miss_cnt;
    logic [3:0]  wb_cnt;

    logic        r_ack;
    logic        ack_force;
    logic        ack_en;
    int          ack_delay;
    int          reqcnt;
    int          req_cycles;
    logic [64:0] log_q[$];

    int total;
    int bad;

    assign mem_ack = r_ack | ack_force;

    cache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_req   (miss_req),
        .miss_we    (miss_we),
        .miss_addr  (miss_addr),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy       (busy),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .err        (err),
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Acks after ack_delay stalled cycles of each access and logs every acked access.
    initial begin
        r_ack = 1'b0;
        reqcnt = 0;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            r_ack = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (ack_en && reqcnt == ack_delay) begin
                    r_ack = 1'b1;
                    log_q.push_back({mem_we, mem_addr, mem_wdata});
                    reqcnt = 0;
                end else begin
                    reqcnt++;
                end
            end else begin
                reqcnt = 0;
            end
        end
    end

    task automatic do_miss(input logic we, input logic [31:0] addr, input logic wbr,
                           input logic [31:0] waddr, input logic [31:0] wdat,
                           output int fcyc, output logic [31:0] fdat);
        fcyc = -1;
        fdat = '0;
        @(negedge clk);
        miss_req = 1'b1; miss_we = we; miss_addr = addr;
        wb_req = wbr; wb_addr = waddr; wb_data = wdat;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                miss_addr = ~addr; wb_addr = ~waddr; wb_data = ~wdat;
                miss_we = ~we; wb_req = ~wbr;
            end
            if (fill_valid) begin
                fcyc = c;
                fdat = fill_data;
                miss_req = 1'b0;
                break;
            end
        end
        miss_req = 1'b0;
    endtask

    initial begin
        int          fc;
        logic [31:0] fd;
        logic        fv_any;
        total = 0; bad = 0;
        rst_n = 1'b0; miss_req = 1'b0; miss_we = 1'b0; miss_addr = '0;
        wb_req = 1'b0; wb_addr = '0; wb_data = '0; mem_rdata = '0;
        ack_force = 1'b0; ack_en = 1'b1; ack_delay = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_err", err, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        rst_n = 1'b1;

        // clean read miss
        log_q.delete(); mem_rdata = 32'hDEADBEEF;
        do_miss(1'b0, 32'h0000_0400, 1'b0, 32'h0, 32'h0, fc, fd);
        chk("clean_fill_cyc", fc, 2);
        chk("clean_fill_data", fd, 32'hDEADBEEF);
        chk("clean_nacc", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("clean_we", log_q[0][64], 0);
            chk("clean_addr", log_q[0][63:32], 32'h400);
        end
        chk("clean_miss_cnt", miss_cnt, 1);
        chk("clean_wb_cnt", wb_cnt, 0);
        @(negedge clk);
        chk("clean_idle_busy", busy, 0);
        chk("clean_idle_fv", fill_valid, 0);

        // dirty read miss
        log_q.delete(); mem_rdata = 32'hCAFEF00D;
        do_miss(1'b0, 32'h0000_0C00, 1'b1, 32'h0000_0800, 32'h12345678, fc, fd);
        chk("dirty_fill_cyc", fc, 3);
        chk("dirty_fill_data", fd, 32'hCAFEF00D);
        chk("dirty_nacc", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("dirty_wb_we", log_q[0][64], 1);
            chk("dirty_wb_addr", log_q[0][63:32], 32'h800);
            chk("dirty_wb_data", log_q[0][31:0], 32'h12345678);
            chk("dirty_rd_we", log_q[1][64], 0);
            chk("dirty_rd_addr", log_q[1][63:32], 32'hC00);
        end
        chk("dirty_wb_cnt", wb_cnt, 1);
        chk("dirty_miss_cnt", miss_cnt, 2);

        // dirty store miss
        log_q.delete(); mem_rdata = 32'h77777777;
        do_miss(1'b1, 32'h0000_1400, 1'b1, 32'h0000_1000, 32'hA5A5A5A5, fc, fd);
        chk("dstore_fill_cyc", fc, 2);
        chk("dstore_fill_data", fd, 0);
        chk("dstore_nacc", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("dstore_we", log_q[0][64], 1);
            chk("dstore_addr", log_q[0][63:32], 32'h1000);
            chk("dstore_data", log_q[0][31:0], 32'hA5A5A5A5);
        end
        chk("dstore_wb_cnt", wb_cnt, 2);

        // clean store miss: no memory traffic at all
        log_q.delete();
        do_miss(1'b1, 32'h0000_1800, 1'b0, 32'h0, 32'h0, fc, fd);
        chk("cstore_fill_cyc", fc, 1);
        chk("cstore_fill_data", fd, 0);
        chk("cstore_nacc", log_q.size(), 0);
        chk("cstore_miss_cnt", miss_cnt, 4);

        // stray ack while idle
        mem_rdata = 32'h99999999;
        @(negedge clk); ack_force = 1'b1;
        @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_mem_req", mem_req, 0);
        ack_force = 1'b0;
        @(negedge clk);
        chk("stray_busy2", busy, 0);
        chk("stray_fill_data", fill_data, 0);
        chk("stray_wb_cnt", wb_cnt, 2);

        // ack on the last watchdog cycle: ack wins
        log_q.delete(); mem_rdata = 32'h5555AAAA; ack_delay = 7;
        do_miss(1'b0, 32'h0000_1C00, 1'b0, 32'h0, 32'h0, fc, fd);
        chk("late_fill_cyc", fc, 9);
        chk("late_fill_data", fd, 32'h5555AAAA);
        chk("late_err", err, 0);

        // timeout: never ack
        log_q.delete(); ack_en = 1'b0; ack_delay = 0; req_cycles = 0;
        do_miss(1'b0, 32'h0000_2000, 1'b0, 32'h0, 32'h0, fc, fd);
        chk("to_fill_cyc", fc, 9);
        chk("to_fill_data", fd, 0);
        chk("to_req_cycles", req_cycles, 8);
        chk("to_err", err, 1);
        @(negedge clk);
        chk("to_idle_busy", busy, 0);
        ack_en = 1'b1; mem_rdata = 32'h11112222;
        do_miss(1'b0, 32'h0000_2400, 1'b0, 32'h0, 32'h0, fc, fd);
        chk("post_to_fill_cyc", fc, 2);
        chk("post_to_fill_data", fd, 32'h11112222);
        chk("post_to_err", err, 1);
        chk("post_to_miss_cnt", miss_cnt, 7);

        // reset in the middle of a read
        ack_en = 1'b0;
        @(negedge clk);
        miss_req = 1'b1; miss_we = 1'b0; miss_addr = 32'h3000; wb_req = 1'b0;
        @(negedge clk); miss_req = 1'b0;
        @(negedge clk);
        chk("mid_rd_mem_req", mem_req, 1);
        chk("mid_rd_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_miss_cnt", miss_cnt, 0);
        chk("arst_err", err, 0);
        @(negedge clk); rst_n = 1'b1; ack_en = 1'b1;
        fv_any = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (fill_valid || busy) fv_any = 1'b1;
        end
        chk("arst_no_fill", fv_any, 0);
        chk("arst_wb_cnt", wb_cnt, 0);

        // miss counter saturation
        for (int i = 0; i < 20; i++) begin
            do_miss(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, fc, fd);
            if (i == 14) chk("sat_at15", miss_cnt, 4'hF);
        end
        chk("sat_at20", miss_cnt, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got=timeout exp=finish");
        $fatal(1);
    end

endmodule
